// File: rtl/register_bank_pkg.sv
// Shared types and constants for the register bank and its users.
// NR here is the default register count; the bank takes NR as an overridable parameter.
package register_bank_pkg;

    localparam int unsigned NR    = 32;
    localparam int unsigned Flags = NR - 1;
    localparam int unsigned PC    = NR - 2;

    typedef logic [4:0]  regind_t;
    typedef logic [31:0] regval_t;

    localparam regval_t Nop = 32'h0000_0000;

    localparam logic [1:0] ShiftLsl = 2'd0;
    localparam logic [1:0] ShiftLsr = 2'd1;
    localparam logic [1:0] ShiftAsr = 2'd2;
    localparam logic [1:0] ShiftRor = 2'd3;

    localparam int unsigned MaxPending = 3;
    localparam int unsigned PendingW   = $clog2(MaxPending + 1);
    typedef logic [PendingW-1:0] pending_t;

endpackage

// File: rtl/register_bank_pending_counter.sv
// Per-register count of issued-but-unwritten claims, saturating at MAX_PENDING.
// busy reports the count as it stands after a same-cycle retire.
module pending_counter
    import register_bank_pkg::*;
#(
    parameter int unsigned MAX_PENDING = MaxPending,
    parameter int unsigned CW          = $clog2(MAX_PENDING + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic claim,
    input  logic retire,
    output logic full,
    output logic busy
);

    localparam logic [CW-1:0] MaxCount = CW'(MAX_PENDING);
    localparam logic [CW-1:0] One      = CW'(1);

    logic [CW-1:0] count_q, count_d;
    logic          nonzero;

    always_comb begin
        nonzero = (count_q != '0);
        full    = (count_q == MaxCount);
        busy    = retire ? (count_q > One) : nonzero;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (claim && !retire && !full) begin
            count_d = count_q + One;
        end else if (retire && !claim && nonzero) begin
            count_d = count_q - One;
        end
        // claim together with retire cancels out, even when full
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Architectural register file with write bypass and per-register pending-write scoreboard.
// Index 0 reads zero, index NR-2 reads the caller's PC, index NR-1 holds the flags.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned NR          = register_bank_pkg::NR,
    parameter int unsigned NREAD       = 3,
    parameter int unsigned MAX_PENDING = MaxPending
) (
    input  logic             clock,
    input  logic             reset,
    input  regind_t          read_register [NREAD],
    input  regval_t          read_pc,
    output regval_t          read_value [NREAD],
    output logic [NREAD-1:0] read_busy,
    output logic             hold,
    input  logic             write_enable,
    input  regind_t          write_register,
    input  regval_t          write_value,
    input  logic             upper_enable,
    input  regval_t          upper_value,
    input  logic             flags_enable,
    input  logic [3:0]       flags,
    input  logic             reserve_enable,
    input  regind_t          reserve_register,
    output logic             reserve_ready,
    output logic             reserve_error,
    input  logic             flush
);

    localparam int unsigned FlagsIdx = NR - 1;
    localparam int unsigned PcIdx    = NR - 2;

    regval_t       regs_q [NR];
    regval_t       regs_d [NR];
    regind_t       upper_register;
    logic [NR-1:0] claim, retire, full, busy;
    logic          reserve_error_q, reserve_error_d;

    always_comb begin
        upper_register = (32'(write_register) == NR - 1) ? '0 : write_register + 5'd1;
    end

    // Next-state values double as the bypass source for same-cycle reads.
    always_comb begin
        for (int unsigned i = 0; i < NR; i++) begin
            regs_d[i] = regs_q[i];
            claim[i]  = 1'b0;
            retire[i] = 1'b0;
            if (i != 0) begin
                claim[i]  = reserve_enable && (i != PcIdx) && (32'(reserve_register) == i);
                retire[i] = (write_enable && (32'(write_register) == i)) ||
                            (upper_enable && (32'(upper_register) == i));
                if (i != PcIdx) begin
                    if (write_enable && (32'(write_register) == i)) begin
                        regs_d[i] = write_value;
                    end else if (upper_enable && (32'(upper_register) == i)) begin
                        regs_d[i] = upper_value;
                    end else if (flags_enable && (i == FlagsIdx)) begin
                        regs_d[i] = {regs_q[i][31:4], flags};
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NR; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_cnt
        pending_counter #(
            .MAX_PENDING(MAX_PENDING)
        ) u_cnt (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .claim (claim[g]),
            .retire(retire[g]),
            .full  (full[g]),
            .busy  (busy[g])
        );
    end

    always_comb begin
        for (int unsigned p = 0; p < NREAD; p++) begin
            read_value[p] = '0;
            read_busy[p]  = 1'b0;
            if (32'(read_register[p]) < NR) begin
                read_busy[p] = busy[read_register[p]];
                if (32'(read_register[p]) == PcIdx) begin
                    read_value[p] = read_pc;
                end else if (read_register[p] != '0) begin
                    read_value[p] = regs_d[read_register[p]];
                end
            end
        end
        hold = |read_busy;
    end

    always_comb begin
        reserve_ready = 1'b1;
        if (32'(reserve_register) < NR) begin
            reserve_ready = !full[reserve_register];
        end
        // Only a claim that cannot be absorbed is an error; a paired retire makes room.
        reserve_error_d = !flush && |(claim & full & ~retire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reserve_error_q <= 1'b0;
        end else begin
            reserve_error_q <= reserve_error_d;
        end
    end

    assign reserve_error = reserve_error_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed-vector bench for register_bank with a per-cycle behavioural reference model.
module tb_register_bank;
    import register_bank_pkg::*;

    localparam int N   = 32;
    localparam int NRD = 3;
    localparam int MP  = 3;
    localparam int PCI = N - 2;
    localparam int FLI = N - 1;

    logic           clock;
    logic           reset;
    regind_t        rd_reg [NRD];
    regval_t        read_pc;
    regval_t        read_value [NRD];
    logic [NRD-1:0] read_busy;
    logic           hold;
    logic           we;
    regind_t        write_register;
    regval_t        write_value;
    logic           ue;
    regval_t        upper_value;
    logic           fe;
    logic [3:0]     flags;
    logic           re;
    regind_t        reserve_register;
    logic           reserve_ready;
    logic           reserve_error;
    logic           flush;

    register_bank #(
        .NR(N), .NREAD(NRD), .MAX_PENDING(MP)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .read_register   (rd_reg),
        .read_pc         (read_pc),
        .read_value      (read_value),
        .read_busy       (read_busy),
        .hold            (hold),
        .write_enable    (we),
        .write_register  (write_register),
        .write_value     (write_value),
        .upper_enable    (ue),
        .upper_value     (upper_value),
        .flags_enable    (fe),
        .flags           (flags),
        .reserve_enable  (re),
        .reserve_register(reserve_register),
        .reserve_ready   (reserve_ready),
        .reserve_error   (reserve_error),
        .flush           (flush)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectors = 0;
    int miscompares = 0;
    bit model_valid = 1'b0;

    logic [31:0] m_regs [N];
    int          m_cnt [N];
    bit          m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: indices in plain integers, writes as ordered overrides.
    function automatic bit released(int i);
        int up;
        up = (int'(write_register) + 1) % N;
        return (i != 0) && ((we && int'(write_register) == i) || (ue && up == i));
    endfunction

    function automatic logic [31:0] m_next(int i);
        logic [31:0] v;
        int up;
        v  = m_regs[i];
        up = (int'(write_register) + 1) % N;
        if (i == 0 || i == PCI) return v;
        if (fe && i == FLI) v[3:0] = flags;
        if (ue && up == i) v = upper_value;
        if (we && int'(write_register) == i) v = write_value;
        return v;
    endfunction

    function automatic logic [31:0] m_read(int idx);
        if (idx == 0) return 32'h0;
        if (idx == PCI) return read_pc;
        return m_next(idx);
    endfunction

    function automatic int m_after(int i);
        int c;
        c = m_cnt[i];
        if (released(i) && c > 0) c--;
        return c;
    endfunction

    always @(posedge clock) begin
        logic [31:0] nregs [N];
        int          ncnt [N];
        int          rr;
        bit          rsv;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_regs[i] = 32'h0;
                m_cnt[i]  = 0;
            end
            m_err       = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            rr  = int'(reserve_register);
            rsv = re && rr != 0 && rr != PCI;
            for (int i = 0; i < N; i++) begin
                nregs[i] = m_next(i);
                ncnt[i]  = m_cnt[i];
                if (flush) begin
                    ncnt[i] = 0;
                end else if (rsv && rr == i && !released(i)) begin
                    if (m_cnt[i] < MP) ncnt[i] = m_cnt[i] + 1;
                end else if (!(rsv && rr == i) && released(i) && m_cnt[i] > 0) begin
                    ncnt[i] = m_cnt[i] - 1;
                end
            end
            m_err = !flush && rsv && m_cnt[rr] == MP && !released(rr);
            for (int i = 0; i < N; i++) begin
                m_regs[i] = nregs[i];
                m_cnt[i]  = ncnt[i];
            end
        end
    end

    always @(negedge clock) begin
        bit any_busy;
        if (model_valid) begin
            any_busy = 1'b0;
            for (int p = 0; p < NRD; p++) begin
                check($sformatf("model rv%0d", p), read_value[p], m_read(int'(rd_reg[p])));
                check($sformatf("model busy%0d", p), 32'(read_busy[p]),
                      32'(m_after(int'(rd_reg[p])) != 0));
                if (m_after(int'(rd_reg[p])) != 0) any_busy = 1'b1;
            end
            check("model hold", 32'(hold), 32'(any_busy));
            check("model ready", 32'(reserve_ready), 32'(m_cnt[int'(reserve_register)] < MP));
            check("model error", 32'(reserve_error), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; read_pc = '0; we = 1'b0; write_register = '0; write_value = '0;
        ue = 1'b0; upper_value = '0; fe = 1'b0; flags = '0; re = 1'b0;
        reserve_register = '0; flush = 1'b0;
        for (int p = 0; p < NRD; p++) rd_reg[p] = '0;
        step();

        // Post-reset reads of zero, PC and an ordinary register
        reset = 1'b0; read_pc = 32'h100;
        rd_reg[0] = 5'd0; rd_reg[1] = 5'd30; rd_reg[2] = 5'd5;
        #1;
        check("reset r0", read_value[0], 32'h0);
        check("reset pc", read_value[1], 32'h100);
        check("reset r5", read_value[2], 32'h0);
        check("reset hold", 32'(hold), 32'h0);
        check("reset busy", 32'(read_busy), 32'h0);
        check("reset error", 32'(reserve_error), 32'h0);

        // Bypass of a same-cycle write
        we = 1'b1; write_register = 5'd5; write_value = 32'hDEADBEEF;
        #1 check("bypass r5", read_value[2], 32'hDEADBEEF);
        step(); we = 1'b0;
        #1 check("stored r5", read_value[2], 32'hDEADBEEF);

        // Saturating claims on r7
        rd_reg[0] = 5'd7; re = 1'b1; reserve_register = 5'd7;
        #1 check("r7 ready at 0", 32'(reserve_ready), 32'h1);
        step(); step(); step();
        check("r7 ready at 3", 32'(reserve_ready), 32'h0);
        check("no error yet", 32'(reserve_error), 32'h0);
        step(); re = 1'b0;
        #1 check("error pulse", 32'(reserve_error), 32'h1);
        check("r7 busy", 32'(read_busy[0]), 32'h1);
        check("hold on r7", 32'(hold), 32'h1);
        step();
        check("error cleared", 32'(reserve_error), 32'h0);
        check("r7 still full", 32'(reserve_ready), 32'h0);

        // Release to 2, then a reserve+release pair, then drain
        we = 1'b1; write_register = 5'd7; write_value = 32'h7;
        step();
        re = 1'b1;
        #1 check("pair busy", 32'(read_busy[0]), 32'h1);
        step(); re = 1'b0;
        #1 check("r7 ready at 2", 32'(reserve_ready), 32'h1);
        check("drain1 busy", 32'(read_busy[0]), 32'h1);
        step();
        check("drain2 busy", 32'(read_busy[0]), 32'h0);
        check("drain2 hold", 32'(hold), 32'h0);
        step(); we = 1'b0;
        #1 check("r7 idle busy", 32'(read_busy[0]), 32'h0);
        check("r7 idle hold", 32'(hold), 32'h0);

        // Upper write wrapping onto r0, then flags priority
        rd_reg[0] = 5'd0; rd_reg[1] = 5'd31;
        ue = 1'b1; write_register = 5'd31; upper_value = 32'h55;
        #1 check("wrap r0 bypass", read_value[0], 32'h0);
        step(); ue = 1'b0;
        #1 check("wrap r0", read_value[0], 32'h0);
        we = 1'b1; write_value = 32'hF0; fe = 1'b1; flags = 4'h3;
        #1 check("flags bypass", read_value[1], 32'hF0);
        step(); we = 1'b0; fe = 1'b0;
        #1 check("flags primary", read_value[1], 32'hF0);
        fe = 1'b1; flags = 4'hA;
        step(); fe = 1'b0;
        #1 check("flags low nibble", read_value[1], 32'hFA);

        // Flush with a concurrent write and reserve
        rd_reg[0] = 5'd3; rd_reg[1] = 5'd9; rd_reg[2] = 5'd5;
        re = 1'b1; reserve_register = 5'd3;
        step(); reserve_register = 5'd9;
        step(); re = 1'b0;
        #1 check("claims busy", 32'(read_busy), 32'h3);
        check("claims hold", 32'(hold), 32'h1);
        flush = 1'b1; re = 1'b1; we = 1'b1; write_register = 5'd3; write_value = 32'h1;
        #1 check("flush r3 bypass", read_value[0], 32'h1);
        step(); flush = 1'b0; re = 1'b0; we = 1'b0;
        #1 check("flush r3", read_value[0], 32'h1);
        check("flush busy", 32'(read_busy), 32'h0);
        check("flush hold", 32'(hold), 32'h0);
        check("flush ready r9", 32'(reserve_ready), 32'h1);
        re = 1'b1;
        step(); re = 1'b0;
        #1 check("r9 one claim", 32'(read_busy[1]), 32'h1);
        we = 1'b1; write_register = 5'd9; write_value = 32'h99;
        step(); we = 1'b0;
        #1 check("r9 released", 32'(read_busy[1]), 32'h0);

        // Reset overrides a same-cycle write and reserve
        reset = 1'b1; we = 1'b1; write_register = 5'd5; write_value = 32'h1234;
        re = 1'b1; reserve_register = 5'd5;
        step(); reset = 1'b0; we = 1'b0; re = 1'b0;
        #1 check("reset wins r5", read_value[2], 32'h0);
        check("reset wins r3", read_value[0], 32'h0);
        check("reset wins hold", 32'(hold), 32'h0);
        check("reset wins error", 32'(reserve_error), 32'h0);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter NR, default 32, number of architectural registers; NR >= 4.
REQ-002 SHALL have parameter NREAD, default 3, number of read ports (left, right, address).
REQ-003 SHALL have parameter MAX_PENDING, default 3, in-flight writes tracked per register.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port read_register  in  NREAD x 5  per-port register index (regind_t).
REQ-007 SHALL have port read_pc  in  32  PC of the reading instruction (regval_t).
REQ-008 SHALL have port read_value  out  NREAD x 32  per-port value, combinational.
REQ-009 SHALL have port read_busy  out  NREAD  per-port flag: the register has pending writes.
REQ-010 SHALL have port hold  out  1  OR of all read_busy bits.
REQ-011 SHALL have ports write_enable (in, 1), write_register (in, 5), write_value (in, 32)  primary write.
REQ-012 SHALL have ports upper_enable (in, 1), upper_value (in, 32)  write of write_register+1 mod NR.
REQ-013 SHALL have ports flags_enable (in, 1), flags (in, 4)  write of Flags[3:0].
REQ-014 SHALL have ports reserve_enable (in, 1), reserve_register (in, 5)  issue-time claim.
REQ-015 SHALL have ports reserve_ready (out, 1), reserve_error (out, 1, registered pulse).
REQ-016 SHALL have port flush  in  1  discard all pending claims.

Function
REQ-017 Register 0 SHALL read 0; writes to it SHALL be ignored and SHALL NOT release claims.
REQ-018 Index PC (NR-2) SHALL read read_pc; writes to it SHALL be ignored but SHALL release claims.
REQ-019 Index Flags (NR-1) SHALL read its stored value; bits [31:4] SHALL be writable only by the primary or upper port.
REQ-020 Writes SHALL take effect at the clock edge; a same-cycle read of the written index SHALL return the new value (bypass).
REQ-021 Write priority per index SHALL be: primary > upper > flags_enable. Losing ports SHALL be dropped for that index.
REQ-022 Each register SHALL hold a pending count 0..MAX_PENDING. A count of 0 is idle.
REQ-023 reserve_enable with count < MAX_PENDING SHALL increment the target count. Reserve on index 0 or PC SHALL be ignored.
REQ-024 reserve_enable with count == MAX_PENDING SHALL leave the count unchanged and SHALL pulse reserve_error for one cycle.
REQ-025 reserve_ready SHALL be combinational: 1 when the count of reserve_register is < MAX_PENDING.
REQ-026 A primary write SHALL decrement the count of write_register; upper_enable SHALL decrement the count of the index+1 register.
REQ-027 A release at count 0 SHALL be ignored; the count SHALL never underflow.
REQ-028 Reserve and release of the same index in one cycle SHALL leave the count unchanged, including at count == MAX_PENDING.
REQ-029 read_busy[i] SHALL reflect counts after same-cycle releases, so a releasing write un-busies the read.
REQ-030 flush SHALL zero every count at the edge and SHALL override reserves that cycle. Register values SHALL be unaffected.
REQ-031 flush SHALL NOT suppress writes arriving in the same cycle.

Reset
REQ-032 On reset all registers, all counts, and reserve_error SHALL be 0.
REQ-033 reset SHALL take precedence over every write, reserve and flush in the same cycle.
REQ-034 read_busy SHALL be 0 in the cycle after reset; hold SHALL be 0 in the cycle after reset.

Structure
REQ-035 regind_t, regval_t, NR, Flags, PC, Nop and the shift-operation constants SHALL stay in the shared package. NR SHALL be overridable.
REQ-036 A new typedef pending_t, sized by MAX_PENDING, SHALL be added to the package.
REQ-037 The per-register claim counter SHALL be a sub-module pending_counter, instantiated NR times.
REQ-038 The storage array and read muxing SHALL live in register_bank.

Verification
REQ-039 Bench SHALL cover: reset, then read index 0, PC and 5 with read_pc=0x100 -> 0, 0x100, 0; hold=0.
REQ-040 Bench SHALL cover: write r5=0xDEADBEEF while reading r5 in the same cycle -> read_value=0xDEADBEEF at once and after the edge.
REQ-041 Bench SHALL cover: reserve r7 three times, then a fourth reserve -> reserve_ready=0, reserve_error pulses once, count stays 3.
REQ-042 Bench SHALL cover: reserve r7 and write r7 in the same cycle at count 2 -> count stays 2; then 2 writes -> read_busy=0, hold=0.
REQ-043 Bench SHALL cover: upper_enable write_register=NR-1 with upper_value=0x55 -> r0 stays 0 (wrap to 0, ignored); primary Flags write 0xF0 plus flags_enable=0x3 -> Flags=0xF0.
REQ-044 Bench SHALL cover: claims on r3 and r9, then flush with a write r3=1 in the same cycle -> all counts 0, r3=1, hold=0.
